// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer, decoder and the ALU itself:
// ALU control codes, request op-class encodings, R-type funct encodings
// and the sequencer FSM state type.
package alu_pkg;

    // ALU control codes (also understood by the ALU)
    localparam logic [3:0] CTRL_AND     = 4'd0;
    localparam logic [3:0] CTRL_OR      = 4'd1;
    localparam logic [3:0] CTRL_ADD     = 4'd2;
    localparam logic [3:0] CTRL_SRL     = 4'd3;
    localparam logic [3:0] CTRL_SRLV    = 4'd4;
    localparam logic [3:0] CTRL_LUI     = 4'd5;
    localparam logic [3:0] CTRL_SUB     = 4'd6;
    localparam logic [3:0] CTRL_SLT     = 4'd7;
    localparam logic [3:0] CTRL_BGEZ    = 4'd8;
    localparam logic [3:0] CTRL_MUL     = 4'd9;
    localparam logic [3:0] CTRL_NOR     = 4'd12;
    localparam logic [3:0] CTRL_ILLEGAL = 4'd15;

    // Request op classes
    localparam logic [2:0] ALUOP_ADD     = 3'b000;
    localparam logic [2:0] ALUOP_SUB     = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE   = 3'b010;
    localparam logic [2:0] ALUOP_SLT     = 3'b011;
    localparam logic [2:0] ALUOP_OR      = 3'b100;
    localparam logic [2:0] ALUOP_LUI     = 3'b101;
    localparam logic [2:0] ALUOP_BGEZ    = 3'b110;
    localparam logic [2:0] ALUOP_ILLEGAL = 3'b111;

    // R-type funct field values
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRLV = 6'h06;
    localparam logic [5:0] FUNCT_MUL  = 6'h18;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_decode.sv
// Combinational decoder: request op class + funct -> ALU control code.
// Unknown op classes and unknown R-type functs map to CTRL_ILLEGAL.
module alu_decode
    import alu_pkg::*;
(
    input  logic [2:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [3:0] ctrl_o,
    output logic       illegal_o
);

    // Map op class (and funct for R-type) onto a control code
    always_comb begin
        ctrl_o = CTRL_ILLEGAL;
        case (aluop_i)
            ALUOP_ADD:  ctrl_o = CTRL_ADD;
            ALUOP_SUB:  ctrl_o = CTRL_SUB;
            ALUOP_SLT:  ctrl_o = CTRL_SLT;
            ALUOP_OR:   ctrl_o = CTRL_OR;
            ALUOP_LUI:  ctrl_o = CTRL_LUI;
            ALUOP_BGEZ: ctrl_o = CTRL_BGEZ;
            ALUOP_RTYPE: begin
                case (funct_i)
                    FUNCT_ADD:  ctrl_o = CTRL_ADD;
                    FUNCT_SUB:  ctrl_o = CTRL_SUB;
                    FUNCT_AND:  ctrl_o = CTRL_AND;
                    FUNCT_OR:   ctrl_o = CTRL_OR;
                    FUNCT_NOR:  ctrl_o = CTRL_NOR;
                    FUNCT_SLT:  ctrl_o = CTRL_SLT;
                    FUNCT_SRL:  ctrl_o = CTRL_SRL;
                    FUNCT_SRLV: ctrl_o = CTRL_SRLV;
                    FUNCT_MUL:  ctrl_o = CTRL_MUL;
                    default:    ctrl_o = CTRL_ILLEGAL;
                endcase
            end
            default: ctrl_o = CTRL_ILLEGAL;
        endcase
    end

    assign illegal_o = (ctrl_o == CTRL_ILLEGAL);

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation at a time: accepts a request, drives the ALU
// from registered operands for a fixed latency, captures the result and
// offers it on the response port until it is taken.
//
// Handshakes: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both 1; a response transfers on a rising edge where
// rsp_valid_o and rsp_ready_i are both 1. Valid, once raised, holds with a
// stable payload until the transfer. Ready is only raised in IDLE (request)
// and valid only in RESP (response), so the two never transfer together.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_aluop_i,
    input  logic [5:0]  req_funct_i,
    input  logic [31:0] req_src1_i,
    input  logic [31:0] req_src2_i,
    input  logic [4:0]  req_shamt_i,
    output logic [31:0] alu_src1_o,
    output logic [31:0] alu_src2_o,
    output logic [4:0]  alu_shamt_o,
    output logic [3:0]  alu_ctrl_o,
    input  logic [31:0] alu_result_i,
    input  logic        alu_zero_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_result_o,
    output logic        rsp_zero_o,
    output logic        rsp_illegal_o,
    output alu_state_e  dbg_state_o
);

    // Counter preload values: EXEC lasts exactly LAT cycles
    localparam logic [3:0] ALU_CNT = 4'(ALU_LAT - 1);
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

    alu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] src1_q, src1_d;
    logic [31:0] src2_q, src2_d;
    logic [4:0]  shamt_q, shamt_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] res_q, res_d;
    logic        zero_q, zero_d;
    logic        ill_q, ill_d;

    logic [3:0]  dec_ctrl;
    logic        dec_illegal;

    alu_decode u_decode (
        .aluop_i   (req_aluop_i),
        .funct_i   (req_funct_i),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal)
    );

    // State, operand and response registers; reset clears everything
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            shamt_q <= '0;
            ctrl_q  <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            shamt_q <= shamt_d;
            ctrl_q  <= ctrl_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in EXEC, hold in RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        shamt_d = shamt_q;
        ctrl_d  = ctrl_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ill_d   = ill_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    src1_d  = req_src1_i;
                    src2_d  = req_src2_i;
                    shamt_d = req_shamt_i;
                    ctrl_d  = dec_ctrl;
                    if (dec_illegal) begin
                        // Nothing for the ALU to do: answer immediately
                        res_d   = '0;
                        zero_d  = 1'b1;
                        ill_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = (dec_ctrl == CTRL_MUL) ? MUL_CNT : ALU_CNT;
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    res_d   = alu_result_i;
                    zero_d  = alu_zero_i;
                    ill_d   = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready is forced low while reset is held so nothing is accepted then
    assign req_ready_o   = rst_i && (state_q == ST_IDLE);
    assign rsp_valid_o   = (state_q == ST_RESP);
    assign rsp_result_o  = res_q;
    assign rsp_zero_o    = zero_q;
    assign rsp_illegal_o = ill_q;
    assign alu_src1_o    = src1_q;
    assign alu_src2_o    = src2_q;
    assign alu_shamt_o   = shamt_q;
    assign alu_ctrl_o    = ctrl_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ALU closes the loop, a request-level
// reference model predicts result, zero, illegal, ctrl code and latency.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int ALU_LAT = 1;
    localparam int MUL_LAT = 3;
    localparam int W = 34;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  req_aluop_i = '0;
    logic [5:0]  req_funct_i = '0;
    logic [31:0] req_src1_i = '0;
    logic [31:0] req_src2_i = '0;
    logic [4:0]  req_shamt_i = '0;
    logic [31:0] alu_src1_o;
    logic [31:0] alu_src2_o;
    logic [4:0]  alu_shamt_o;
    logic [3:0]  alu_ctrl_o;
    logic [31:0] alu_result_i;
    logic        alu_zero_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_result_o;
    logic        rsp_zero_o;
    logic        rsp_illegal_o;
    alu_state_e  dbg_state_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    alu_sequencer #(.ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_aluop_i(req_aluop_i), .req_funct_i(req_funct_i),
        .req_src1_i(req_src1_i), .req_src2_i(req_src2_i), .req_shamt_i(req_shamt_i),
        .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
        .alu_shamt_o(alu_shamt_o), .alu_ctrl_o(alu_ctrl_o),
        .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_zero_o(rsp_zero_o),
        .rsp_illegal_o(rsp_illegal_o), .dbg_state_o(dbg_state_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    // Behavioural ALU driven by the sequencer
    always_comb begin
        case (alu_ctrl_o)
            CTRL_AND:  alu_result_i = alu_src1_o & alu_src2_o;
            CTRL_OR:   alu_result_i = alu_src1_o | alu_src2_o;
            CTRL_ADD:  alu_result_i = alu_src1_o + alu_src2_o;
            CTRL_SRL:  alu_result_i = alu_src2_o >> alu_shamt_o;
            CTRL_SRLV: alu_result_i = alu_src2_o >> alu_src1_o[4:0];
            CTRL_LUI:  alu_result_i = {alu_src2_o[15:0], 16'h0000};
            CTRL_SUB:  alu_result_i = alu_src1_o - alu_src2_o;
            CTRL_SLT:  alu_result_i = {31'd0, $signed(alu_src1_o) < $signed(alu_src2_o)};
            CTRL_BGEZ: alu_result_i = {31'd0, ~alu_src1_o[31]};
            CTRL_MUL:  alu_result_i = alu_src1_o * alu_src2_o;
            CTRL_NOR:  alu_result_i = ~(alu_src1_o | alu_src2_o);
            default:   alu_result_i = 32'hDEAD_BEEF;
        endcase
        alu_zero_i = (alu_result_i == 32'd0);
    end

    // Request-level reference: what the operation means, its ctrl code and latency
    task automatic ref_model(input logic [2:0] aluop, input logic [5:0] funct,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                             output logic [31:0] res, output logic ill,
                             output logic [3:0] ctrl, output int cycles);
        int lat;
        int signed sa, sb;
        sa = a; sb = b;
        ill = 1'b0; res = 32'd0; ctrl = 4'd15; lat = ALU_LAT;
        case (aluop)
            3'd0: begin res = a + b; ctrl = 4'd2; end
            3'd1: begin res = a - b; ctrl = 4'd6; end
            3'd3: begin res = (sa < sb) ? 32'd1 : 32'd0; ctrl = 4'd7; end
            3'd4: begin res = a | b; ctrl = 4'd1; end
            3'd5: begin res = b * 32'd65536; ctrl = 4'd5; end
            3'd6: begin res = (sa >= 0) ? 32'd1 : 32'd0; ctrl = 4'd8; end
            3'd2: begin
                case (funct)
                    6'h20: begin res = a + b; ctrl = 4'd2; end
                    6'h22: begin res = a - b; ctrl = 4'd6; end
                    6'h24: begin res = a & b; ctrl = 4'd0; end
                    6'h25: begin res = a | b; ctrl = 4'd1; end
                    6'h27: begin res = ~(a | b); ctrl = 4'd12; end
                    6'h2A: begin res = (sa < sb) ? 32'd1 : 32'd0; ctrl = 4'd7; end
                    6'h02: begin res = b >> sh; ctrl = 4'd3; end
                    6'h06: begin res = b >> (a % 32); ctrl = 4'd4; end
                    6'h18: begin res = a * b; ctrl = 4'd9; lat = MUL_LAT; end
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            res = 32'd0; ctrl = 4'd15; cycles = 1;
        end else begin
            cycles = 1 + lat;
        end
    endtask

    // Drive one request, check latency and payload, hold the response for
    // 'hold' cycles with rsp_ready_i low, then take it
    task automatic run_op(input string name, input logic [2:0] aluop, input logic [5:0] funct,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                          input int hold);
        logic [31:0] e_res;
        logic        e_ill, e_zero;
        logic [3:0]  e_ctrl;
        int          e_cyc, n;
        logic [W-1:0] e_pkt, got;
        ref_model(aluop, funct, a, b, sh, e_res, e_ill, e_ctrl, e_cyc);
        e_zero = e_ill ? 1'b1 : (e_res == 32'd0);
        exp_q.push_back({e_ill, e_zero, e_res});

        @(negedge clk_i);
        n_checks++;
        if (req_ready_o !== 1'b1) $display("FAIL %s ready_before got=%b want=1", name, req_ready_o);
        else n_pass++;
        req_valid_i = 1'b1; req_aluop_i = aluop; req_funct_i = funct;
        req_src1_i = a; req_src2_i = b; req_shamt_i = sh;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        req_src1_i = $urandom; req_src2_i = $urandom; req_shamt_i = 5'($urandom);
        @(negedge clk_i);
        n = 1;
        while (rsp_valid_o !== 1'b1 && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        n_checks++;
        if (n !== e_cyc) $display("FAIL %s latency got=%0d want=%0d", name, n, e_cyc);
        else n_pass++;
        e_pkt = exp_q.pop_front();
        got = {rsp_illegal_o, rsp_zero_o, rsp_result_o};
        n_checks++;
        if (got !== e_pkt) $display("FAIL %s payload got=%h want=%h", name, got, e_pkt);
        else n_pass++;
        n_checks++;
        if (alu_ctrl_o !== e_ctrl) $display("FAIL %s ctrl got=%0d want=%0d", name, alu_ctrl_o, e_ctrl);
        else n_pass++;
        n_checks++;
        if ({alu_src1_o, alu_src2_o, alu_shamt_o} !== {a, b, sh})
            $display("FAIL %s alu_operands got=%h/%h/%h want=%h/%h/%h", name,
                     alu_src1_o, alu_src2_o, alu_shamt_o, a, b, sh);
        else n_pass++;
        n_checks++;
        if (req_ready_o !== 1'b0) $display("FAIL %s ready_in_resp got=%b want=0", name, req_ready_o);
        else n_pass++;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            n_checks++;
            if (rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0 ||
                {rsp_illegal_o, rsp_zero_o, rsp_result_o} !== e_pkt)
                $display("FAIL %s hold%0d got=%b%b/%h want=10/%h", name, i,
                         rsp_valid_o, req_ready_o, {rsp_illegal_o, rsp_zero_o, rsp_result_o}, e_pkt);
            else n_pass++;
        end
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || dbg_state_o !== ST_IDLE)
            $display("FAIL %s back_to_idle got=%b%b state=%0d want=01 state=0", name,
                     rsp_valid_o, req_ready_o, dbg_state_o);
        else n_pass++;
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({rsp_valid_o, req_ready_o, rsp_result_o, rsp_zero_o, rsp_illegal_o,
             alu_src1_o, alu_src2_o, alu_shamt_o, alu_ctrl_o} !== '0)
            $display("FAIL %s outputs got=%b%b %h %b%b %h %h %h %h want=all 0", name,
                     rsp_valid_o, req_ready_o, rsp_result_o, rsp_zero_o, rsp_illegal_o,
                     alu_src1_o, alu_src2_o, alu_shamt_o, alu_ctrl_o);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_all_zero("reset");
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (req_ready_o !== 1'b1) $display("FAIL reset_release ready got=%b want=1", req_ready_o);
        else n_pass++;
    endtask

    task automatic test_directed();
        run_op("add_5_7", 3'b000, 6'h00, 32'd5, 32'd7, 5'd0, 0);
        run_op("mul_6_7", 3'b010, 6'h18, 32'd6, 32'd7, 5'd0, 0);
        run_op("sub_backpressure", 3'b001, 6'h00, 32'd9, 32'd9, 5'd0, 5);
        run_op("illegal_funct", 3'b010, 6'h3F, 32'd1, 32'd2, 5'd3, 1);
        run_op("illegal_aluop", 3'b111, 6'h20, 32'd4, 32'd4, 5'd0, 0);
        run_op("lui", 3'b101, 6'h00, 32'd0, 32'h0000_1234, 5'd0, 0);
        run_op("slt_neg", 3'b011, 6'h00, 32'hFFFF_FFFF, 32'd1, 5'd0, 0);
        run_op("bgez_neg", 3'b110, 6'h00, 32'h8000_0000, 32'd0, 5'd0, 0);
        run_op("nor", 3'b010, 6'h27, 32'hF0F0_0000, 32'h0F0F_0000, 5'd0, 0);
        run_op("srlv", 3'b010, 6'h06, 32'd35, 32'h8000_0000, 5'd0, 2);
    endtask

    task automatic test_ready_outside_resp();
        @(negedge clk_i);
        rsp_ready_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            n_checks++;
            if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1)
                $display("FAIL idle_rsp_ready got=%b%b want=01", rsp_valid_o, req_ready_o);
            else n_pass++;
        end
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk_i);
        req_valid_i = 1'b1; req_aluop_i = 3'b010; req_funct_i = 6'h18;
        req_src1_i = 32'd11; req_src2_i = 32'd13; req_shamt_i = 5'd7;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        n_checks++;
        if (req_ready_o !== 1'b0) $display("FAIL midop_ready_in_reset got=%b want=0", req_ready_o);
        else n_pass++;
        @(negedge clk_i);
        check_all_zero("midop_reset");
        rst_i = 1'b1;
        run_op("srl_after_reset", 3'b010, 6'h02, 32'd0, 32'h80, 5'd4, 0);
        n_checks++;
        if (rsp_result_o !== 32'h08) $display("FAIL srl_after_reset_value got=%h want=00000008", rsp_result_o);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [5:0] functs[9];
        logic [5:0] f;
        logic [31:0] a, b;
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h02, 6'h06, 6'h18};
        for (int i = 0; i < 40; i++) begin
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : functs[$urandom_range(0, 8)];
            a = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), f, a, b,
                   5'($urandom), $urandom_range(0, 3));
        end
    endtask

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_ready_outside_resp();
        test_reset_mid_op();
        test_random();
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_empty got=%0d want=0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter ALU_LAT, default 1: cycles EXEC waits before capturing a non-MUL ALU result (legal range 1..15).
REQ-002 Parameter MUL_LAT, default 3: cycles EXEC waits before capturing a MUL result (legal range 1..15).
REQ-003 clk_i  in  1: single clock; all state changes on rising edge.
REQ-004 rst_i  in  1: reset, synchronous, active-low.
REQ-005 req_valid_i  in  1: request valid.
REQ-006 req_ready_o  out  1: request ready.
REQ-007 req_aluop_i  in  3: op class. 000 ADD, 001 SUB, 010 R-type (use funct), 011 SLT, 100 OR, 101 LUI, 110 BGEZ, 111 illegal.
REQ-008 req_funct_i  in  6: R-type funct. 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT, 0x02 SRL, 0x06 SRLV, 0x18 MUL; all other values are illegal.
REQ-009 req_src1_i / req_src2_i  in  32 each; req_shamt_i  in  5: operands.
REQ-010 alu_src1_o / alu_src2_o  out  32; alu_shamt_o  out  5; alu_ctrl_o  out  4: drive the ALU.
REQ-011 alu_result_i  in  32; alu_zero_i  in  1: combinational ALU outputs.
REQ-012 rsp_valid_o  out  1; rsp_ready_i  in  1: response handshake.
REQ-013 rsp_result_o  out  32; rsp_zero_o  out  1; rsp_illegal_o  out  1: response payload.

Function
REQ-014 Control codes SHALL be AND=0, OR=1, ADD=2, SRL=3, SRLV=4, LUI=5, SUB=6, SLT=7, BGEZ=8, MUL=9, NOR=12, ILLEGAL=15.
REQ-015 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-016 IDLE: req_ready_o=1. When req_valid_i=1, the block SHALL register the operands and the decoded ctrl.
  - Legal op: go to EXEC; load counter with (ctrl==MUL ? MUL_LAT : ALU_LAT)-1.
  - Illegal op: go directly to RESP with result=0, zero=1, illegal=1.
REQ-017 EXEC: req_ready_o=0; alu_* outputs SHALL be driven from the registered values.
  - Counter nonzero: decrement.
  - Counter zero: capture alu_result_i and alu_zero_i into response registers, set illegal=0, go to RESP.
REQ-018 RESP: rsp_valid_o=1; payload held stable until rsp_valid_o & rsp_ready_i; on that handshake go to IDLE.
REQ-019 Outside RESP, rsp_valid_o SHALL be 0.
REQ-020 req_ready_o SHALL be 1 only in IDLE; a request and a response handshake never complete in the same cycle.
REQ-021 Timing: request accepted in cycle T, legal op SHALL give rsp_valid_o=1 in cycle T+1+LAT; illegal op SHALL give rsp_valid_o=1 in cycle T+1.
REQ-022 alu_* outputs SHALL hold their last registered values in IDLE and RESP; no combinational path from req_* to alu_*.
REQ-023 rsp_result_o, rsp_zero_o and rsp_illegal_o SHALL be registered; no combinational path from alu_result_i to rsp_*.
REQ-024 rsp_ready_i asserted outside RESP SHALL be ignored.
REQ-025 The sequencer SHALL pass operands and results through without arithmetic or width changes; width handling belongs to the ALU.

Reset
REQ-026 When rst_i=0 at a clock edge:
  - state = IDLE, counter = 0;
  - all alu_* outputs = 0;
  - rsp_result_o = 0, rsp_zero_o = 0, rsp_illegal_o = 0, rsp_valid_o = 0.
REQ-027 req_ready_o SHALL be 0 while rst_i=0, and 1 in the first cycle after rst_i rises.
REQ-028 Reset during EXEC or RESP SHALL abort the operation; the pending response is discarded.

Structure
REQ-029 A shared package alu_pkg SHALL hold the ctrl code constants, the aluop encodings, the funct encodings and the FSM state type; the ALU uses the same ctrl constants.
REQ-030 Decode SHALL be a separate combinational sub-module alu_decode (aluop, funct -> ctrl, illegal).

Verification
REQ-031 ADD: aluop=000, src1=5, src2=7, ALU_LAT=1, accepted cycle T -> rsp_valid_o at T+2, result=12, zero=0, illegal=0, alu_ctrl_o=2.
REQ-032 MUL: aluop=010, funct=0x18, src1=6, src2=7, MUL_LAT=3, accepted T -> rsp_valid_o at T+4, result=42, alu_ctrl_o=9.
REQ-033 Backpressure: SUB 9-9, rsp_ready_i=0 for 5 cycles -> rsp_valid_o=1, result=0, zero=1 held stable for all 5 cycles; req_ready_o=0 throughout; IDLE the cycle after rsp_ready_i=1.
REQ-034 Illegal: aluop=010, funct=0x3F -> rsp_valid_o at T+1, illegal=1, result=0, zero=1; alu_ctrl_o=15.
REQ-035 Reset mid-op: MUL accepted, rst_i=0 at T+2 -> next cycle rsp_valid_o=0, req_ready_o=0, all outputs 0; after release, SRL src2=0x80, shamt=4 -> result=0x08.
